aemb_dwb_bridge: RTL

- Registered Wishbone master bridge directly downstream of the core's data port (dwb_stb_o/dwb_wre_o/dwb_adr_o/dwb_sel_o/dwb_dat_o, dwb_ack_i/dwb_dat_i).
- Converts the core's hold-until-ack request into a full Wishbone classic cycle (cyc/stb/we/sel, ack/err).
- Adds a bus timeout watchdog and a sticky error-capture register, so a dead slave cannot hang the pipeline.

---
 rtl/aemb_dwb_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aemb_dwb_bridge.sv
// aemb_dwb_bridge: registered Wishbone classic master sitting behind the core's data port.
// Turns the core's hold-until-ack request into a single cyc/stb bus cycle, returns read
// data with a one-cycle cpu_ack_o pulse, and guards against dead slaves with a timeout.
// Failed accesses (wb_err_i or timeout) are recorded in a sticky error-capture register.
//
// Ports:
//   sys_clk_i, sys_rst_i       clock (rising edge), asynchronous active-low reset
//   cpu_stb_i .. cpu_dat_i     core request (held until cpu_ack_o)
//   cpu_dat_o, cpu_ack_o       read data and single-cycle completion pulse
//   wb_cyc_o .. wb_dat_o       Wishbone master outputs (registered)
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave responses
//   err_clr_i                  clears err_o / err_tmo_o
//   err_o, err_tmo_o, err_adr_o   sticky error flag, timeout-vs-bus-error, failing address
module aemb_dwb_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TW      = 8,
  parameter int unsigned TMO_LIM = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          cpu_stb_i,
  input  logic          cpu_wre_i,
  input  logic [AW-3:0] cpu_adr_i,
  input  logic [3:0]    cpu_sel_i,
  input  logic [31:0]   cpu_dat_i,
  output logic [31:0]   cpu_dat_o,
  output logic          cpu_ack_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-3:0] wb_adr_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          err_clr_i,
  output logic          err_o,
  output logic          err_tmo_o,
  output logic [AW-3:0] err_adr_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [TW-1:0] TmoLim = TW'(TMO_LIM);
  localparam logic [TW-1:0] CntMax = {TW{1'b1}};

  logic [1:0]    stateQ, stateD;
  logic [TW-1:0] cntQ, cntD;
  logic          weQ, weD;
  logic [AW-3:0] adrQ, adrD;
  logic [3:0]    selQ, selD;
  logic [31:0]   wdatQ, wdatD;
  logic [31:0]   rdatQ, rdatD;
  logic          errQ, errD;
  logic          errTmoQ, errTmoD;
  logic [AW-3:0] errAdrQ, errAdrD;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    weD     = weQ;
    adrD    = adrQ;
    selD    = selQ;
    wdatD   = wdatQ;
    rdatD   = rdatQ;
    errD    = errQ;
    errTmoD = errTmoQ;
    errAdrD = errAdrQ;

    // Clear first so that an error captured on the same edge overrides it.
    if (err_clr_i) begin
      errD    = 1'b0;
      errTmoD = 1'b0;
    end

    case (stateQ)
      StIdle: begin
        if (cpu_stb_i) begin
          stateD = StReq;
          cntD   = '0;
          weD    = cpu_wre_i;
          adrD   = cpu_adr_i;
          selD   = cpu_sel_i;
          wdatD  = cpu_dat_i;
        end
      end
      StReq: begin
        if (cntQ != CntMax) cntD = cntQ + TW'(1);
        if (wb_err_i) begin
          stateD  = StResp;
          errD    = 1'b1;
          errTmoD = 1'b0;
          errAdrD = adrQ;
          if (!weQ) rdatD = 32'hFFFF_FFFF;
        end else if (wb_ack_i) begin
          stateD = StResp;
          if (!weQ) rdatD = wb_dat_i;
        end else if (cntQ == TmoLim) begin
          stateD  = StResp;
          errD    = 1'b1;
          errTmoD = 1'b1;
          errAdrD = adrQ;
          if (!weQ) rdatD = 32'hFFFF_FFFF;
        end
      end
      StResp: begin
        // The core sees cpu_ack_o this cycle; a held cpu_stb_i is not re-sampled here.
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      weQ     <= 1'b0;
      adrQ    <= '0;
      selQ    <= '0;
      wdatQ   <= '0;
      rdatQ   <= '0;
      errQ    <= 1'b0;
      errTmoQ <= 1'b0;
      errAdrQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      weQ     <= weD;
      adrQ    <= adrD;
      selQ    <= selD;
      wdatQ   <= wdatD;
      rdatQ   <= rdatD;
      errQ    <= errD;
      errTmoQ <= errTmoD;
      errAdrQ <= errAdrD;
    end
  end

  // Strobes decode directly from the state flop, so reset drops them without a clock edge.
  assign wb_cyc_o  = (stateQ == StReq);
  assign wb_stb_o  = (stateQ == StReq);
  assign cpu_ack_o = (stateQ == StResp);
  assign wb_we_o   = weQ;
  assign wb_adr_o  = adrQ;
  assign wb_sel_o  = selQ;
  assign wb_dat_o  = wdatQ;
  assign cpu_dat_o = rdatQ;
  assign err_o     = errQ;
  assign err_tmo_o = errTmoQ;
  assign err_adr_o = errAdrQ;

endmodule
